// File: rtl/snn_pkg.sv
// snn_pkg: definitions shared across the SNN readout blocks.
//   decoder_state_t : spike_rate_decoder FSM states
//   V_WIDTH         : membrane-potential width used across the SNN fabric
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SCAN  = 2'd2,
        HOLD  = 2'd3
    } decoder_state_t;

    localparam int V_WIDTH = 16;

endpackage

// File: rtl/spike_counter.sv
// spike_counter: saturating up-counter for one output neuron.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears count
//   clr   : synchronous clear, takes priority over inc
//   inc   : add one this cycle (held at all-ones once reached)
//   count : current count
module spike_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts output-layer spikes over WINDOW cycles, then
// scans the counts one neuron per cycle for the argmax and presents the
// result on a valid/ready handshake.
//   clk, rst_n    : clock (rising edge), synchronous active-low reset
//   start         : begin a window (sampled only in IDLE)
//   spikes_in     : one spike bit per neuron for the current cycle
//   busy          : high while counting or scanning
//   result_valid  : result held and offered to the consumer
//   result_ready  : consumer accepts the result
//   winner_idx    : index of the highest count (lowest index on ties)
//   winner_count  : count of the winner
//   tie           : another neuron matched a non-zero winner_count
//   no_spike      : all counts were zero
//   count_sel     : debug readback select
//   count_out     : live count of neuron count_sel (0 if out of range)
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = 10,
    parameter int WINDOW      = 256,
    localparam int CNT_W      = $clog2(WINDOW + 1),
    localparam int IDX_W      = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_NEURONS-1:0] spikes_in,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [IDX_W-1:0]       winner_idx,
    output logic [CNT_W-1:0]       winner_count,
    output logic                   tie,
    output logic                   no_spike,
    input  logic [IDX_W-1:0]       count_sel,
    output logic [CNT_W-1:0]       count_out
);

    decoder_state_t state, state_nx;

    logic [NUM_NEURONS-1:0][CNT_W-1:0] counts;
    logic [NUM_NEURONS-1:0]            cnt_inc;
    logic                              cnt_clr;

    logic [CNT_W-1:0] win_cnt;
    logic [IDX_W-1:0] scan_idx;

    logic             win_last;
    logic             scan_last;
    logic [CNT_W-1:0] scan_cur;
    logic [IDX_W-1:0] idx_nx;
    logic [CNT_W-1:0] max_nx;
    logic             tie_nx;

    // ---------------- per-neuron counters ----------------
    assign cnt_clr = (state == IDLE) && start;

    genvar g;
    generate
        for (g = 0; g < NUM_NEURONS; g++) begin : g_cnt
            assign cnt_inc[g] = (state == COUNT) && spikes_in[g];

            spike_counter #(.W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (cnt_clr),
                .inc   (cnt_inc[g]),
                .count (counts[g])
            );
        end
    endgenerate

    // ---------------- FSM ----------------
    assign win_last  = (win_cnt == CNT_W'(WINDOW - 1));
    assign scan_last = (scan_idx == IDX_W'(NUM_NEURONS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = COUNT;
            COUNT: begin
                busy = 1'b1;
                if (win_last) state_nx = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (scan_last) state_nx = HOLD;
            end
            HOLD: begin
                result_valid = 1'b1;
                if (result_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- argmax step ----------------
    // Mux by compare loop so no index ever runs past NUM_NEURONS-1 when
    // NUM_NEURONS is not a power of two.
    always_comb begin
        scan_cur  = '0;
        count_out = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (scan_idx == IDX_W'(i))  scan_cur  = counts[i];
            if (count_sel == IDX_W'(i)) count_out = counts[i];
        end
    end

    // Neuron 0 seeds the running max; afterwards only a strictly greater
    // count displaces it, so the lowest index keeps a tie.
    always_comb begin
        idx_nx = winner_idx;
        max_nx = winner_count;
        tie_nx = tie;
        if (scan_idx == '0) begin
            idx_nx = '0;
            max_nx = scan_cur;
            tie_nx = 1'b0;
        end else if (scan_cur > winner_count) begin
            idx_nx = scan_idx;
            max_nx = scan_cur;
            tie_nx = 1'b0;
        end else if ((scan_cur == winner_count) && (winner_count != '0)) begin
            tie_nx = 1'b1;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt      <= '0;
            scan_idx     <= '0;
            winner_idx   <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
            no_spike     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        win_cnt  <= '0;
                        scan_idx <= '0;
                    end
                end
                COUNT: begin
                    win_cnt <= win_cnt + 1'b1;
                end
                SCAN: begin
                    winner_idx   <= idx_nx;
                    winner_count <= max_nx;
                    tie          <= tie_nx;
                    if (scan_last) begin
                        scan_idx <= '0;
                        // a zero max means no index ever displaced 0 and no
                        // tie was flagged, so idx=0/tie=0 already hold
                        no_spike <= (max_nx == '0);
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;
    localparam int N = 4;
    localparam int W = 16;
    localparam int CW = $clog2(W + 1);
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  spikes_in;
    logic          busy;
    logic          result_valid;
    logic          result_ready;
    logic [IW-1:0] winner_idx;
    logic [CW-1:0] winner_count;
    logic          tie;
    logic          no_spike;
    logic [IW-1:0] count_sel;
    logic [CW-1:0] count_out;

    int ncmp = 0;
    int nfail = 0;
    int lat;
    logic [N-1:0] pat [1:W];

    always #5 clk = ~clk;

    spike_rate_decoder #(.NUM_NEURONS(N), .WINDOW(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .spikes_in    (spikes_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .winner_idx   (winner_idx),
        .winner_count (winner_count),
        .tie          (tie),
        .no_spike     (no_spike),
        .count_sel    (count_sel),
        .count_out    (count_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int sel, input int exp);
        count_sel = IW'(sel);
        #1;
        chk(tag, int'(count_out), exp);
    endtask

    // Start pulse at E0 (with e0sp on the spike lines), pat[1..W] at E1..EW,
    // then wait (bounded) for result_valid; lat = edges from E0 to valid.
    task automatic run_window(input logic [N-1:0] e0sp, output int l);
        start = 1'b1; spikes_in = e0sp;
        step();
        start = 1'b0; l = 0;
        for (int k = 1; k <= W; k++) begin
            spikes_in = pat[k];
            step();
            l++;
        end
        spikes_in = '0;
        while (!result_valid && l < 60) begin
            step();
            l++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; spikes_in = '0;
        result_ready = 1'b1; count_sel = '0;
        step(); step();

        // reset state
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_idx", int'(winner_idx), 0);
        chk("rst_wcount", int'(winner_count), 0);
        chk("rst_tie", int'(tie), 0);
        chk("rst_nospike", int'(no_spike), 0);
        chk_cnt("rst_cnt0", 0, 0);
        rst_n = 1'b1;
        step();

        // basic: n2 every cycle, n0 on odd cycles -> 16 / 8
        for (int k = 1; k <= W; k++) pat[k] = (k % 2 == 1) ? 4'b0101 : 4'b0100;
        start = 1'b1;
        step();
        chk("t1_busy_after_e0", int'(busy), 1);
        start = 1'b0;
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        run_window(4'b0000, lat);
        chk("t1_latency", lat, 20);
        chk("t1_valid", int'(result_valid), 1);
        chk("t1_idx", int'(winner_idx), 2);
        chk("t1_wcount", int'(winner_count), 16);
        chk("t1_tie", int'(tie), 0);
        chk("t1_nospike", int'(no_spike), 0);
        chk_cnt("t1_cnt0", 0, 8);
        chk_cnt("t1_cnt1", 1, 0);
        chk_cnt("t1_cnt2", 2, 16);
        step();
        chk("t1_valid_1cyc", int'(result_valid), 0);
        chk("t1_idle_busy", int'(busy), 0);
        chk("t1_hold_idx", int'(winner_idx), 2);

        // tie between n1 and n3, then backpressure
        for (int k = 1; k <= W; k++) pat[k] = (k <= 5) ? 4'b1010 : 4'b0000;
        result_ready = 1'b0;
        run_window(4'b0000, lat);
        chk("t2_latency", lat, 20);
        chk("t2_idx", int'(winner_idx), 1);
        chk("t2_wcount", int'(winner_count), 5);
        chk("t2_tie", int'(tie), 1);
        chk_cnt("t2_cnt3", 3, 5);
        count_sel = 2'd1;
        for (int i = 0; i < 10; i++) begin
            spikes_in = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            start = (i % 2 == 0);
            step();
            chk("bp_valid", int'(result_valid), 1);
            chk("bp_idx", int'(winner_idx), 1);
            chk("bp_wcount", int'(winner_count), 5);
            chk("bp_tie", int'(tie), 1);
            chk("bp_cnt1", int'(count_out), 5);
        end
        start = 1'b0; spikes_in = '0; result_ready = 1'b1;
        step();
        chk("bp_release_valid", int'(result_valid), 0);
        chk("bp_release_busy", int'(busy), 0);
        step();
        chk("bp_still_idle", int'(busy), 0);

        // silence
        for (int k = 1; k <= W; k++) pat[k] = '0;
        run_window(4'b0000, lat);
        chk("t3_latency", lat, 20);
        chk("t3_nospike", int'(no_spike), 1);
        chk("t3_idx", int'(winner_idx), 0);
        chk("t3_wcount", int'(winner_count), 0);
        chk("t3_tie", int'(tie), 0);
        step();

        // reset mid-COUNT
        start = 1'b1; step(); start = 1'b0;
        spikes_in = 4'b1111;
        for (int k = 1; k <= 6; k++) step();
        chk_cnt("t4_pre_cnt3", 3, 6);
        chk("t4_pre_busy", int'(busy), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; spikes_in = '0;
        chk("t4_busy", int'(busy), 0);
        for (int i = 0; i < N; i++) chk_cnt("t4_cnt_clr", i, 0);
        for (int k = 1; k <= W; k++) pat[k] = 4'b1000;
        run_window(4'b0000, lat);
        chk("t4_latency", lat, 20);
        chk("t4_idx", int'(winner_idx), 3);
        chk("t4_wcount", int'(winner_count), 16);
        chk_cnt("t4_cnt0", 0, 0);
        step();

        // spikes only in the E0 cycle are not counted
        for (int k = 1; k <= W; k++) pat[k] = '0;
        run_window(4'b1111, lat);
        chk("t5_latency", lat, 20);
        chk("t5_nospike", int'(no_spike), 1);
        for (int i = 0; i < N; i++) chk_cnt("t5_cnt", i, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
